// File: rtl/synth_pkg.sv
// Shared types, widths and helpers for the wavetable voice scheduler.
package synth_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} sched_state_t;

   localparam int WT_ADDR_W   = 9;
   localparam int WT_SAMPLE_W = 24;
   localparam int RATE_W      = 24;

   function automatic int mix_width(input int n);
      return WT_SAMPLE_W + $clog2(n);
   endfunction

endpackage

// File: rtl/voice_phase_counter.sv
// Per-voice phase accumulator: steps the wavetable index once every rate+1 cycles while gated on.
module voice_phase_counter #(
   parameter int ADDR_W = synth_pkg::WT_ADDR_W,
   parameter int RATE_W = synth_pkg::RATE_W
) (
   input  logic              clk_in,
   input  logic              rst_n_in,
   input  logic              note_on_in,
   input  logic [RATE_W-1:0] rate_in,
   output logic [ADDR_W-1:0] index_out
);

   logic [RATE_W-1:0] count_q, count_d;
   logic [ADDR_W-1:0] index_q, index_d;

   // Index wraps naturally at the table size because it is exactly ADDR_W bits.
   always_comb begin
      count_d = count_q + RATE_W'(1);
      index_d = index_q;
      if (!note_on_in) begin
         count_d = '0;
         index_d = '0;
      end else if (count_q >= rate_in) begin
         count_d = '0;
         index_d = index_q + ADDR_W'(1);
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         count_q <= '0;
         index_q <= '0;
      end else begin
         count_q <= count_d;
         index_q <= index_d;
      end
   end

   assign index_out = index_q;

endmodule

// File: rtl/wavetable_voice_scheduler.sv
// Shares one pipelined wavetable read port among NUM_VOICES voices and sums
// one sample per active voice on every audio sample tick.
module wavetable_voice_scheduler #(
   parameter int NUM_VOICES  = 4,
   parameter int SAMPLE_W    = synth_pkg::WT_SAMPLE_W,
   parameter int ADDR_W      = synth_pkg::WT_ADDR_W,
   parameter int RATE_W      = synth_pkg::RATE_W,
   parameter int RAM_LATENCY = 2
) (
   input  logic                                   clk_in,
   input  logic                                   rst_n_in,
   input  logic [NUM_VOICES-1:0]                  note_on_in,
   input  logic [NUM_VOICES*RATE_W-1:0]           playback_rate_in,
   input  logic                                   sample_tick_in,
   output logic [ADDR_W-1:0]                      ram_addr_out,
   output logic                                   ram_en_out,
   input  logic [SAMPLE_W-1:0]                    ram_data_in,
   output logic [SAMPLE_W+$clog2(NUM_VOICES)-1:0] mix_out,
   output logic                                   mix_valid_out,
   output logic                                   busy_out,
   output logic                                   overrun_out
);
   import synth_pkg::*;

   localparam int MIX_W = SAMPLE_W + $clog2(NUM_VOICES);
   localparam int VP_W  = $clog2(NUM_VOICES);
   localparam int DR_W  = $clog2(RAM_LATENCY + 1);

   sched_state_t           state_q;
   logic [VP_W-1:0]        voice_q;
   logic [DR_W-1:0]        drain_q;
   logic [RAM_LATENCY-1:0] tag_q;
   logic [MIX_W-1:0]       acc_q;
   logic [MIX_W-1:0]       mix_q;
   logic                   mix_valid_q;
   logic                   overrun_q;
   logic [ADDR_W-1:0]      index [NUM_VOICES];
   logic                   issue_tag;
   logic [MIX_W-1:0]       sample_ext;

   for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
      voice_phase_counter #(
         .ADDR_W (ADDR_W),
         .RATE_W (RATE_W)
      ) u_phase (
         .clk_in     (clk_in),
         .rst_n_in   (rst_n_in),
         .note_on_in (note_on_in[g]),
         .rate_in    (playback_rate_in[g*RATE_W +: RATE_W]),
         .index_out  (index[g])
      );
   end

   // Each voice's gate and index are taken live in its own ISSUE slot.
   always_comb begin
      ram_addr_out = '0;
      ram_en_out   = 1'b0;
      issue_tag    = 1'b0;
      if (state_q == ISSUE) begin
         ram_addr_out = index[voice_q];
         ram_en_out   = note_on_in[voice_q];
         issue_tag    = note_on_in[voice_q];
      end
   end

   assign sample_ext = {{(MIX_W-SAMPLE_W){ram_data_in[SAMPLE_W-1]}}, ram_data_in};

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q     <= IDLE;
         voice_q     <= '0;
         drain_q     <= '0;
         tag_q       <= '0;
         acc_q       <= '0;
         mix_q       <= '0;
         mix_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         mix_valid_q <= 1'b0;
         // Tag leaves the shift register in the same cycle its read data returns.
         tag_q <= RAM_LATENCY'({tag_q, issue_tag});
         if (tag_q[RAM_LATENCY-1]) acc_q <= acc_q + sample_ext;
         if (sample_tick_in && (state_q != IDLE)) overrun_q <= 1'b1;
         case (state_q)
            IDLE: begin
               if (sample_tick_in) begin
                  acc_q   <= '0;
                  voice_q <= '0;
                  state_q <= ISSUE;
               end
            end
            ISSUE: begin
               voice_q <= voice_q + VP_W'(1);
               if (voice_q == VP_W'(NUM_VOICES-1)) begin
                  drain_q <= '0;
                  state_q <= DRAIN;
               end
            end
            DRAIN: begin
               drain_q <= drain_q + DR_W'(1);
               if (drain_q == DR_W'(RAM_LATENCY-1)) state_q <= DONE;
            end
            DONE: begin
               mix_q       <= acc_q;
               mix_valid_q <= 1'b1;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign mix_out       = mix_q;
   assign mix_valid_out = mix_valid_q;
   assign busy_out      = (state_q != IDLE);
   assign overrun_out   = overrun_q;

endmodule

// File: tb/tb_wavetable_voice_scheduler.sv
// Bench for wavetable_voice_scheduler: table of voice setups plus hand-written
// reset, gating, overrun, single-voice and wrap sequences against a RAM model.
module tb_wavetable_voice_scheduler;

   localparam int MW = 26;

   logic          clk_in = 1'b0;
   logic          rst_n_in = 1'b1;
   logic [3:0]    note_on_in = '0;
   logic [95:0]   playback_rate_in = '0;
   logic          sample_tick_in = 1'b0;
   logic [8:0]    ram_addr_out;
   logic          ram_en_out;
   logic [23:0]   ram_data_in = '0;
   logic [MW-1:0] mix_out;
   logic          mix_valid_out;
   logic          busy_out;
   logic          overrun_out;

   wavetable_voice_scheduler dut (
      .clk_in           (clk_in),
      .rst_n_in         (rst_n_in),
      .note_on_in       (note_on_in),
      .playback_rate_in (playback_rate_in),
      .sample_tick_in   (sample_tick_in),
      .ram_addr_out     (ram_addr_out),
      .ram_en_out       (ram_en_out),
      .ram_data_in      (ram_data_in),
      .mix_out          (mix_out),
      .mix_valid_out    (mix_valid_out),
      .busy_out         (busy_out),
      .overrun_out      (overrun_out)
   );

   always #5 clk_in = ~clk_in;

   // Two-cycle read RAM; disabled reads return junk so stray accumulation shows up.
   logic [23:0] ram [512];
   logic [23:0] rd_s1 = '0;
   always @(posedge clk_in) begin
      rd_s1       <= ram_en_out ? ram[ram_addr_out] : 24'h5A5A5A;
      ram_data_in <= rd_s1;
   end

   int checks = 0;
   int failures = 0;
   logic [MW-1:0] exp_q[$];

   typedef struct {
      logic [3:0]    on;
      logic [95:0]   rates;
      int            wcyc;
      logic [23:0]   ram0;
      logic [MW-1:0] exp_mix;
   } vec_t;
   vec_t vecs[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic fill_ram(input bit ramp);
      for (int k = 0; k < 512; k++) ram[k] = ramp ? 24'(k) : 24'(k - 256);
   endtask

   // One clear cycle, then gate on and let wcyc gated edges pass before the tick.
   task automatic setup_voices(input logic [3:0] on, input logic [95:0] rates, input int wcyc);
      @(negedge clk_in);
      note_on_in = '0;
      playback_rate_in = rates;
      @(negedge clk_in);
      note_on_in = on;
      repeat (wcyc) @(negedge clk_in);
   endtask

   // Tick in cycle 0, observe cycles 1..16; mix_valid_out is due in cycle 8.
   task automatic run_frame(input string name, input logic [MW-1:0] exp_mix, input int extra_n,
                            input int slot, input logic [8:0] slot_addr, input logic slot_en,
                            input logic exp_ovr);
      int first_n;
      int pulses;
      logic [MW-1:0] e;
      first_n = 0;
      pulses = 0;
      exp_q.push_back(exp_mix);
      sample_tick_in = 1'b1;
      for (int n = 1; n <= 16; n++) begin
         @(negedge clk_in);
         if (n == 1) check({name, "_busy"}, 32'(busy_out), 32'd1);
         if (n == slot + 1) begin
            check({name, "_slot_addr"}, 32'(ram_addr_out), 32'(slot_addr));
            check({name, "_slot_en"}, 32'(ram_en_out), 32'(slot_en));
         end
         if (mix_valid_out) begin
            pulses++;
            if (first_n == 0) begin
               first_n = n;
               e = exp_q.pop_front();
               check({name, "_mix"}, 32'(mix_out), 32'(e));
            end
         end
         sample_tick_in = (n == extra_n);
      end
      sample_tick_in = 1'b0;
      if (first_n == 0 && exp_q.size() > 0) e = exp_q.pop_front();
      check({name, "_pulses"}, 32'(pulses), 32'd1);
      check({name, "_latency"}, 32'(first_n), 32'd8);
      check({name, "_hold"}, 32'(mix_out), 32'(exp_mix));
      check({name, "_idle"}, 32'(busy_out), 32'd0);
      check({name, "_overrun"}, 32'(overrun_out), 32'(exp_ovr));
   endtask

   initial begin
      int pulses;
      vecs[0] = '{4'b1111, {24'd3, 24'd2, 24'd1, 24'd0}, 9, 24'hFFFF00, MW'(-1002)};
      vecs[1] = '{4'b1001, {24'd1, 24'd5, 24'd5, 24'd0}, 9, 24'hFFFF00, MW'(-496)};
      vecs[2] = '{4'b0000, 96'd0, 5, 24'hFFFF00, MW'(0)};
      vecs[3] = '{4'b0100, {24'd0, 24'd5, 24'd0, 24'd0}, 20, 24'hFFFF00, MW'(-253)};
      vecs[4] = '{4'b1111, {24'd4, 24'd5, 24'd6, 24'd7}, 30, 24'hFFFF00, MW'(-1006)};
      vecs[5] = '{4'b1111, {4{24'hFFFFFF}}, 2, 24'h800000, 26'h2000000};
      vecs[6] = '{4'b1111, {4{24'hFFFFFF}}, 2, 24'h7FFFFF, 26'h1FFFFFC};
      fill_ram(1'b0);

      #1 rst_n_in = 1'b0;
      repeat (2) @(negedge clk_in);
      check("rst_mix", 32'(mix_out), 32'd0);
      check("rst_valid", 32'(mix_valid_out), 32'd0);
      check("rst_busy", 32'(busy_out), 32'd0);
      check("rst_overrun", 32'(overrun_out), 32'd0);
      check("rst_en", 32'(ram_en_out), 32'd0);
      check("rst_addr", 32'(ram_addr_out), 32'd0);
      rst_n_in = 1'b1;

      for (int i = 0; i < 7; i++) begin
         ram[0] = vecs[i].ram0;
         setup_voices(vecs[i].on, vecs[i].rates, vecs[i].wcyc);
         run_frame($sformatf("vec%0d", i), vecs[i].exp_mix, 0, -1, '0, 1'b0, 1'b0);
      end
      ram[0] = 24'hFFFF00;

      // Gating: voice 2 dropped right at the tick reads index 0 with enable low.
      setup_voices(4'b1111, {24'd3, 24'd2, 24'd1, 24'd0}, 9);
      run_frame("gate_all", MW'(-1002), 0, 2, 9'd4, 1'b1, 1'b0);
      note_on_in = 4'b1011;
      run_frame("gate_drop", MW'(-722), 0, 2, 9'd0, 1'b0, 1'b0);

      // Tick during DONE counts as busy.
      check("ovr_clear", 32'(overrun_out), 32'd0);
      setup_voices(4'b0001, {4{24'hFFFFFF}}, 2);
      run_frame("done_tick", MW'(-256), 7, 0, 9'd0, 1'b1, 1'b1);

      // Reset in the middle of ISSUE abandons the frame.
      setup_voices(4'b0001, {4{24'hFFFFFF}}, 2);
      sample_tick_in = 1'b1;
      @(negedge clk_in);
      sample_tick_in = 1'b0;
      @(negedge clk_in);
      check("mid_busy", 32'(busy_out), 32'd1);
      rst_n_in = 1'b0;
      #1;
      check("mid_rst_mix", 32'(mix_out), 32'd0);
      check("mid_rst_valid", 32'(mix_valid_out), 32'd0);
      check("mid_rst_busy", 32'(busy_out), 32'd0);
      check("mid_rst_overrun", 32'(overrun_out), 32'd0);
      check("mid_rst_en", 32'(ram_en_out), 32'd0);
      check("mid_rst_addr", 32'(ram_addr_out), 32'd0);
      repeat (2) @(negedge clk_in);
      rst_n_in = 1'b1;
      pulses = 0;
      for (int n = 0; n < 14; n++) begin
         @(negedge clk_in);
         if (mix_valid_out) pulses++;
      end
      check("mid_rst_no_pulse", 32'(pulses), 32'd0);
      check("mid_rst_ovr_low", 32'(overrun_out), 32'd0);

      // Second tick three cycles into the frame.
      run_frame("overrun", MW'(-256), 3, 0, 9'd0, 1'b1, 1'b1);

      // Single voice on a ramp table, ticks 100 cycles apart.
      fill_ram(1'b1);
      setup_voices(4'b0001, {72'd0, 24'd3}, 3);
      for (int k = 0; k < 4; k++) begin
         run_frame($sformatf("single%0d", k), MW'(1 + 25 * k), 0, 0, 9'(1 + 25 * k), 1'b1, 1'b1);
         if (k < 3) repeat (84) @(negedge clk_in);
      end

      // Rate 0 wraps the index through 511 back to the bottom of the table.
      setup_voices(4'b0001, 96'd0, 510);
      run_frame("wrap_top", MW'(511), 0, 0, 9'd511, 1'b1, 1'b1);
      run_frame("wrap_over", MW'(15), 0, 0, 9'd15, 1'b1, 1'b1);
      setup_voices(4'b0001, 96'd0, 511);
      run_frame("wrap_zero", MW'(0), 0, 0, 9'd0, 1'b1, 1'b1);

      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
